// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
//   Constants and types shared by the instruction-fetch unit.
//
//   RESET_PC     first fetch address after reset
//   FETCH_BYTES  byte distance between consecutive sequential fetches
//   fetch_state_e
//     ST_RUN     fetch requests may issue
//     ST_ERR     a bus error was seen; issue is blocked until a redirect
// -----------------------------------------------------------------------------
package ifu_pkg;

  localparam logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000;
  localparam int unsigned FETCH_BYTES = 4;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } fetch_state_e;

endpackage : ifu_pkg

// File: rtl/ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifu_fetch_ctrl
//   Instruction-fetch sequencer feeding the write side of the IFU instruction
//   FIFO. Sequential fetch requests go out on the memory port; in-order
//   responses are pushed into the FIFO. A request is only started when the
//   FIFO is guaranteed to have room for its response, counting both words
//   already in the FIFO and responses still in flight. A redirect flushes the
//   FIFO, restarts fetch at the new PC and drops every response that belongs
//   to the old stream.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   redirect_valid  flush the FIFO and restart fetching at redirect_pc
//   redirect_pc     new fetch address
//   fifo_pop        consumer read handshake (FIFO read & !empty)
//   fifo_wready     FIFO write enable (combinational from the response)
//   fifo_wdata      FIFO write data (zero when not writing)
//   fifo_flush      FIFO flush (combinational from redirect_valid)
//   req_valid       fetch request valid; held with req_addr until req_ready
//   req_ready       memory accepts the request
//   req_addr        fetch address
//   rsp_valid       response valid; in order, always accepted
//   rsp_data        response data
//   rsp_err         response carries a bus error
//   fetch_err       one-cycle pulse for an error response that is not dropped
// -----------------------------------------------------------------------------
module ifu_fetch_ctrl #(
  parameter int unsigned          DATA_LEN    = 32,
  parameter int unsigned          ADDR_LEN    = 64,
  parameter int unsigned          DEPTH_W     = 6,
  parameter int unsigned          MAX_OUTST   = 4,
  parameter logic [ADDR_LEN-1:0]  RESET_PC    = ADDR_LEN'(ifu_pkg::RESET_PC),
  parameter int unsigned          FETCH_BYTES = ifu_pkg::FETCH_BYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid,
  input  logic [ADDR_LEN-1:0] redirect_pc,
  input  logic                fifo_pop,
  output logic                fifo_wready,
  output logic [DATA_LEN-1:0] fifo_wdata,
  output logic                fifo_flush,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [ADDR_LEN-1:0] req_addr,
  input  logic                rsp_valid,
  input  logic [DATA_LEN-1:0] rsp_data,
  input  logic                rsp_err,
  output logic                fetch_err
);

  import ifu_pkg::*;

  // Counters are one bit wider than the FIFO address so that a full FIFO
  // (2**DEPTH_W words) is representable. The credit rule keeps
  // occ + outst + pending <= 2**DEPTH_W, so their sum never wraps.
  localparam int unsigned         CNT_W      = DEPTH_W + 1;
  localparam logic [CNT_W-1:0]    FIFO_WORDS = CNT_W'(2 ** DEPTH_W);
  localparam logic [CNT_W-1:0]    OUTST_LIM  = CNT_W'(MAX_OUTST);
  localparam logic [ADDR_LEN-1:0] PC_STEP    = ADDR_LEN'(FETCH_BYTES);

  // ---------------------------------------------------------------------------
  // State
  //   pc_q       address of the next request to be presented
  //   req_*_q    the request currently presented on the memory port
  //   occ_q      mirror of the FIFO word count
  //   outst_q    requests accepted by memory but not yet answered
  //   discard_q  upcoming responses that belong to a dead stream
  // ---------------------------------------------------------------------------
  fetch_state_e        state_q,   state_d;
  logic [ADDR_LEN-1:0] pc_q;
  logic                req_valid_q;
  logic [ADDR_LEN-1:0] req_addr_q;
  logic [CNT_W-1:0]    occ_q,     occ_d;
  logic [CNT_W-1:0]    outst_q,   outst_d;
  logic [CNT_W-1:0]    discard_q, discard_d;

  logic accept;     // request handshake completes this cycle
  logic pend_hold;  // presented request stalls and must stay on the port
  logic rsp_drop;   // this cycle's response belongs to a dead stream
  logic rsp_live;   // this cycle's response is consumed by the current stream
  logic push;       // response data written into the FIFO
  logic err_hit;    // live error response
  logic issue;      // present a fresh request next cycle

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    occ_d     = occ_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    accept    = req_valid_q & req_ready;
    pend_hold = req_valid_q & ~req_ready;
    rsp_drop  = discard_q != '0;
    rsp_live  = 1'b0;
    push      = 1'b0;
    err_hit   = 1'b0;
    issue     = 1'b0;

    // Redirect wins over everything: a same-cycle response is treated as part
    // of the old stream and neither pushed nor reported.
    rsp_live = rst_n & rsp_valid & ~rsp_drop & ~redirect_valid;
    push     = rsp_live & ~rsp_err;
    err_hit  = rsp_live &  rsp_err;

    outst_d = outst_q + CNT_W'(accept) - CNT_W'(rsp_valid);

    if (redirect_valid) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + CNT_W'(push) - CNT_W'(fifo_pop);
    end

    // Both a redirect and an error kill the current stream. Everything still
    // in flight after this cycle, including a stalled request that memory
    // will accept later, must have its response dropped.
    if (redirect_valid || err_hit) begin
      discard_d = outst_d + CNT_W'(pend_hold);
    end else if (rsp_valid && rsp_drop) begin
      discard_d = discard_q - 1'b1;
    end

    if (redirect_valid) begin
      state_d = ST_RUN;
    end else if (err_hit) begin
      state_d = ST_ERR;
    end

    // Credit is checked against next-cycle counts, so the request presented
    // next cycle already has a guaranteed FIFO slot for its response.
    issue = (state_d == ST_RUN) && !redirect_valid &&
            (outst_d < OUTST_LIM) && ((occ_d + outst_d) < FIFO_WORDS);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before the clock edge regardless of
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      occ_q       <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;

      // A stalled request keeps both valid and address, even across a
      // redirect or an error; its response is dropped via discard_q.
      req_valid_q <= pend_hold | issue;
      if (!pend_hold && issue) begin
        req_addr_q <= pc_q;
      end

      // pc_q advances as a request is presented (wrapping at 2**ADDR_LEN).
      // A redirect suppresses issue this cycle, so the two never collide.
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (!pend_hold && issue) begin
        pc_q <= pc_q + PC_STEP;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The combinational outputs are gated by rst_n so every output reads zero
  // while reset is asserted, whatever the memory side is still driving.
  assign req_valid   = req_valid_q;
  assign req_addr    = req_addr_q;
  assign fifo_wready = push;
  assign fifo_wdata  = push ? rsp_data : '0;
  assign fifo_flush  = rst_n & redirect_valid;
  assign fetch_err   = err_hit;

endmodule : ifu_fetch_ctrl

// File: tb/tb_ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch_ctrl
//   Directed bench for ifu_fetch_ctrl with a 4-word FIFO (DEPTH_W = 2).
//   A simple in-order memory model answers accepted requests after a
//   configurable latency; a FIFO count model drives fifo_pop. Expected request
//   addresses and FIFO write data are queued when a scenario is set up and
//   popped as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_ifu_fetch_ctrl;

  localparam int unsigned DATA_LEN   = 32;
  localparam int unsigned ADDR_LEN   = 64;
  localparam int unsigned DEPTH_W    = 2;
  localparam int unsigned MAX_OUTST  = 4;
  localparam int          FIFO_WORDS = 4;
  localparam logic [63:0] PC0        = 64'h0000_0000_8000_0000;

  logic                clk;
  logic                rst_n;
  logic                redirect_valid;
  logic [ADDR_LEN-1:0] redirect_pc;
  logic                fifo_pop;
  logic                fifo_wready;
  logic [DATA_LEN-1:0] fifo_wdata;
  logic                fifo_flush;
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_LEN-1:0] req_addr;
  logic                rsp_valid;
  logic [DATA_LEN-1:0] rsp_data;
  logic                rsp_err;
  logic                fetch_err;

  ifu_fetch_ctrl #(
    .DATA_LEN  (DATA_LEN),
    .ADDR_LEN  (ADDR_LEN),
    .DEPTH_W   (DEPTH_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_pop       (fifo_pop),
    .fifo_wready    (fifo_wready),
    .fifo_wdata     (fifo_wdata),
    .fifo_flush     (fifo_flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts reported in the summary line.
  int n_vec  = 0;
  int n_miss = 0;

  // Environment state.
  int          cyc = 0;
  logic [63:0] mem_q[$];
  int          mem_due[$];
  logic [63:0] exp_req[$];
  logic [31:0] exp_data[$];
  int fcount, max_occ, pushes, accepts, rsp_idx, err_idx, ferr_cnt;
  int first_push, last_push, lat, n_acc;
  bit nx_ready, nx_redirect, pop_en, rsp_en, strict, chk_credit;
  logic [63:0] nx_redirect_pc;

  function automatic logic [31:0] dfun(input logic [63:0] a);
    return a[31:0] ^ 32'hC3A5_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    req_ready      = nx_ready;
    redirect_valid = nx_redirect;
    redirect_pc    = nx_redirect_pc;
    if (rsp_en && mem_q.size() > 0 && mem_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = dfun(mem_q[0]);
      rsp_err   = (rsp_idx == err_idx);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
    end
    fifo_pop = pop_en && (fcount > 0);
    #1;
    if (chk_credit && (fcount + mem_q.size()) >= FIFO_WORDS)
      check("credit_block", 64'(req_valid), 64'd0);
    if (fifo_wready) begin
      pushes++;
      if (first_push < 0) first_push = cyc;
      last_push = cyc;
      if (exp_data.size() > 0) check("push_data", 64'(fifo_wdata), 64'(exp_data.pop_front()));
      else if (strict) check("push_unexpected", 64'(fifo_wready), 64'd0);
    end
    if (fetch_err) ferr_cnt++;
    if (req_valid && req_ready) begin
      accepts++;
      if (exp_req.size() > 0) check("req_addr", req_addr, exp_req.pop_front());
      mem_q.push_back(req_addr);
      mem_due.push_back(cyc + lat);
    end
    if (rsp_valid) begin
      mem_q.delete(0);
      mem_due.delete(0);
      rsp_idx++;
    end
    if (fifo_flush) fcount = 0;
    else fcount = fcount + int'(fifo_wready) - int'(fifo_pop);
    if (fcount > max_occ) max_occ = fcount;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fifo_pop       = 1'b0;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    rsp_err        = 1'b0;
    mem_q.delete();
    mem_due.delete();
    exp_req.delete();
    exp_data.delete();
    fcount = 0; max_occ = 0; pushes = 0; accepts = 0; rsp_idx = 0; ferr_cnt = 0;
    first_push = -1; last_push = -1; lat = 1; err_idx = -1;
    nx_ready = 1'b1; nx_redirect = 1'b0; nx_redirect_pc = '0;
    pop_en = 1'b1; rsp_en = 1'b1; strict = 1'b0; chk_credit = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int limit);
    for (int i = 0; i < limit && exp_data.size() > 0; i++) cycle();
    check({tag, "_drained"}, 64'(exp_data.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_valid"},   64'(req_valid),   64'd0);
    check({tag, "_req_addr"},    req_addr,         64'd0);
    check({tag, "_fifo_wready"}, 64'(fifo_wready), 64'd0);
    check({tag, "_fifo_wdata"},  64'(fifo_wdata),  64'd0);
    check({tag, "_fifo_flush"},  64'(fifo_flush),  64'd0);
    check({tag, "_fetch_err"},   64'(fetch_err),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Reset state, with live-looking inputs on every port ----
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1234;
    fifo_pop       = 1'b1;
    req_ready      = 1'b1;
    rsp_valid      = 1'b1;
    rsp_data       = 32'hDEAD_BEEF;
    rsp_err        = 1'b0;
    #12;
    check_outputs_zero("reset");

    // ---- Streaming: one request and one push per cycle ----
    do_reset();
    strict = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(PC0 + 64'(4 * i));
      exp_data.push_back(dfun(PC0 + 64'(4 * i)));
    end
    drain("stream", 40);
    check("stream_pushes", 64'(pushes), 64'd8);
    check("stream_span", 64'(last_push - first_push), 64'd7);
    check("stream_max_occ", 64'(max_occ), 64'd1);

    // ---- No pops: credit stops at a full FIFO, one pop frees one slot ----
    do_reset();
    pop_en = 1'b0; strict = 1'b1; chk_credit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(PC0 + 64'(4 * i));
      exp_data.push_back(dfun(PC0 + 64'(4 * i)));
    end
    repeat (20) cycle();
    check("fill_pushes", 64'(pushes), 64'd4);
    check("fill_accepts", 64'(accepts), 64'd4);
    check("fill_req_idle", 64'(req_valid), 64'd0);
    exp_req.push_back(PC0 + 64'd16);
    exp_data.push_back(dfun(PC0 + 64'd16));
    pop_en = 1'b1;
    cycle();
    pop_en = 1'b0;
    repeat (10) cycle();
    check("refill_pushes", 64'(pushes), 64'd5);
    check("refill_accepts", 64'(accepts), 64'd5);
    check("refill_occ", 64'(fcount), 64'd4);

    // ---- Redirect with 3 requests outstanding ----
    do_reset();
    rsp_en = 1'b0; strict = 1'b1;
    exp_req.push_back(PC0);
    exp_req.push_back(PC0 + 64'd4);
    exp_req.push_back(PC0 + 64'd8);
    exp_req.push_back(64'h1000);
    exp_req.push_back(64'h1004);
    exp_data.push_back(dfun(64'h1000));
    exp_data.push_back(dfun(64'h1004));
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) cycle();
    nx_redirect = 1'b1; nx_redirect_pc = 64'h1000;
    cycle();
    check("redir_flush", 64'(fifo_flush), 64'd1);
    check("redir_outst", 64'(mem_q.size()), 64'd3);
    nx_redirect = 1'b0; rsp_en = 1'b1;
    cycle();
    check("redir_flush_pulse", 64'(fifo_flush), 64'd0);
    drain("redir", 40);
    check("redir_pushes", 64'(pushes), 64'd2);

    // ---- Redirect while a request is stalled on req_ready ----
    do_reset();
    nx_ready = 1'b0; strict = 1'b1;
    for (int i = 0; i < 10 && !req_valid; i++) cycle();
    check("pend_valid", 64'(req_valid), 64'd1);
    check("pend_addr", req_addr, PC0);
    nx_redirect = 1'b1; nx_redirect_pc = 64'h1000;
    cycle();
    nx_redirect = 1'b0;
    repeat (2) begin
      cycle();
      check("pend_hold_valid", 64'(req_valid), 64'd1);
      check("pend_hold_addr", req_addr, PC0);
    end
    exp_req.push_back(PC0);
    exp_req.push_back(64'h1000);
    exp_data.push_back(dfun(64'h1000));
    nx_ready = 1'b1;
    drain("pend", 40);

    // ---- Error on the second response ----
    do_reset();
    err_idx = 1; strict = 1'b1;
    exp_req.push_back(PC0);
    exp_req.push_back(PC0 + 64'd4);
    exp_data.push_back(dfun(PC0));
    for (int i = 0; i < 20 && ferr_cnt == 0; i++) cycle();
    check("err_pulse", 64'(fetch_err), 64'd1);
    check("err_no_push", 64'(fifo_wready), 64'd0);
    cycle();
    check("err_pulse_len", 64'(fetch_err), 64'd0);
    n_acc = accepts;
    repeat (15) cycle();
    check("err_no_new_req", 64'(accepts), 64'(n_acc));
    check("err_req_idle", 64'(req_valid), 64'd0);
    check("err_pushes", 64'(pushes), 64'd1);
    check("err_pulse_count", 64'(ferr_cnt), 64'd1);
    exp_req.push_back(64'h2000);
    exp_data.push_back(dfun(64'h2000));
    nx_redirect = 1'b1; nx_redirect_pc = 64'h2000;
    cycle();
    nx_redirect = 1'b0;
    drain("err_resume", 40);

    // ---- PC wrap at the top of the address space ----
    do_reset();
    nx_ready = 1'b0; strict = 1'b1;
    exp_req.push_back(PC0);
    exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_req.push_back(64'h0);
    exp_data.push_back(dfun(64'hFFFF_FFFF_FFFF_FFFC));
    exp_data.push_back(dfun(64'h0));
    nx_redirect = 1'b1; nx_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    nx_redirect = 1'b0; nx_ready = 1'b1;
    drain("wrap", 40);

    // ---- Reset in the middle of traffic ----
    do_reset();
    rsp_en = 1'b0;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) cycle();
    check("midrst_outst", 64'(mem_q.size()), 64'd2);
    @(negedge clk);
    rst_n          = 1'b0;
    rsp_valid      = 1'b1;
    rsp_data       = 32'h1234_5678;
    rsp_err        = 1'b0;
    fifo_pop       = 1'b1;
    redirect_valid = 1'b0;
    #1;
    check_outputs_zero("midrst");
    do_reset();
    exp_req.push_back(PC0);
    for (int i = 0; i < 10 && accepts == 0; i++) cycle();
    check("midrst_first_req", 64'(accepts != 0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_ifu_fetch_ctrl
